// File: rtl/tree_router_nary_if.sv
// Handshake bundle for tree_router_nary. It carries the flattened per-port
// valid/ready/data channels in both directions and the drop counter.
interface tree_router_nary_if #(
  parameter int WIDTH_PACKET = 14,
  parameter int NUM_CHILD    = 2,
  parameter int DROP_CNT_W   = 8
);
  localparam int NUM_PORTS = NUM_CHILD + 1;

  logic [NUM_PORTS-1:0]              in_valid;
  logic [NUM_PORTS-1:0]              in_ready;
  logic [NUM_PORTS*WIDTH_PACKET-1:0] in_data;
  logic [NUM_PORTS-1:0]              out_valid;
  logic [NUM_PORTS-1:0]              out_ready;
  logic [NUM_PORTS*WIDTH_PACKET-1:0] out_data;
  logic [DROP_CNT_W-1:0]             drop_count;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, drop_count
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, drop_count
  );
endinterface

// File: rtl/tree_router_nary.sv
// N-ary tree NoC router: one parent port plus NUM_CHILD child ports. Each input
// has a FIFO, and each output has a round-robin arbiter feeding a one-entry register.
module tree_router_nary #(
  parameter int                WIDTH_PACKET = 14,
  parameter int                NUM_CHILD    = 2,
  parameter int                FIFO_DEPTH   = 4,
  parameter int                ADDR_W       = 3,
  parameter int                DEST_LSB     = 0,
  parameter logic [ADDR_W-1:0] ROUTER_ID    = 3'b000,
  parameter logic [ADDR_W-1:0] ROUTER_MASK  = 3'b110,
  parameter int                DROP_CNT_W   = 8
) (
  input logic               clk,
  input logic               rst_n,
  tree_router_nary_if.slave io_bus
);
  localparam int NUM_PORTS = NUM_CHILD + 1;
  localparam int CSEL_W    = (NUM_CHILD > 1) ? $clog2(NUM_CHILD) : 1;
  localparam int PTR_W     = $clog2(NUM_PORTS);
  localparam int AW        = $clog2(FIFO_DEPTH);
  localparam int CNT_W     = AW + 1;
  localparam int NDROP_W   = $clog2(NUM_PORTS + 1);

  localparam logic [CSEL_W:0]       CHILD_LIM = (CSEL_W + 1)'(NUM_CHILD);
  localparam logic [DROP_CNT_W:0]   DROP_MAX  = {1'b0, {DROP_CNT_W{1'b1}}};

  logic [WIDTH_PACKET-1:0] r_mem [NUM_PORTS][FIFO_DEPTH];
  logic [AW-1:0]           r_rdPtr [NUM_PORTS];
  logic [AW-1:0]           r_wrPtr [NUM_PORTS];
  logic [CNT_W-1:0]        r_count [NUM_PORTS];
  logic [NUM_PORTS-1:0]    r_outValid;
  logic [WIDTH_PACKET-1:0] r_outData [NUM_PORTS];
  logic [PTR_W-1:0]        r_arbPtr [NUM_PORTS];
  logic [DROP_CNT_W-1:0]   r_dropCount;

  logic [NUM_PORTS-1:0]    w_push;
  logic [NUM_PORTS-1:0]    w_pop;
  logic [NUM_PORTS-1:0]    w_full;
  logic [NUM_PORTS-1:0]    w_headValid;
  logic [NUM_PORTS-1:0]    w_drop;
  logic [WIDTH_PACKET-1:0] w_head [NUM_PORTS];
  logic [PTR_W-1:0]        w_target [NUM_PORTS];
  logic [NUM_PORTS-1:0]    w_grantValid;
  logic [PTR_W-1:0]        w_grantIdx [NUM_PORTS];
  logic [NDROP_W-1:0]      w_numDrops;
  logic [DROP_CNT_W:0]     w_dropSum;

  assign io_bus.in_ready   = rst_n ? ~w_full : '0;
  assign io_bus.out_valid  = r_outValid;
  assign io_bus.drop_count = r_dropCount;
  assign w_push            = io_bus.in_valid & io_bus.in_ready;

  // Each FIFO head resolves to exactly one target port, or to a drop.
  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_route
    logic [ADDR_W-1:0] w_dest;
    logic [CSEL_W-1:0] w_idx;
    logic              w_match;
    logic [PTR_W-1:0]  w_tgt;
    logic              w_drp;

    assign w_headValid[p] = (r_count[p] != '0);
    assign w_full[p]      = (r_count[p] == CNT_W'(FIFO_DEPTH));
    assign w_head[p]      = r_mem[p][r_rdPtr[p]];
    assign w_dest         = w_head[p][DEST_LSB +: ADDR_W];
    assign w_match        = (((w_dest ^ ROUTER_ID) & ROUTER_MASK) == '0);
    assign w_idx          = w_dest[CSEL_W-1:0];

    always_comb begin
      w_tgt = '0;
      w_drp = 1'b0;
      if (w_match) begin
        if ({1'b0, w_idx} < CHILD_LIM) w_tgt = PTR_W'(w_idx) + PTR_W'(1);
        else                           w_drp = w_headValid[p];
      end else if (p == 0) begin
        w_drp = w_headValid[p];
      end
    end

    assign w_target[p] = w_tgt;
    assign w_drop[p]   = w_drp;
    assign io_bus.out_data[p*WIDTH_PACKET +: WIDTH_PACKET] = r_outData[p];
  end

  // Round-robin search starting at the output's pointer, wrapping modulo NUM_PORTS.
  always_comb begin : p_arb
    int   v_cand;
    logic v_found;
    v_cand  = 0;
    v_found = 1'b0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      w_grantValid[o] = 1'b0;
      w_grantIdx[o]   = '0;
      v_found         = 1'b0;
      if (!r_outValid[o] || io_bus.out_ready[o]) begin
        for (int k = 0; k < NUM_PORTS; k++) begin
          v_cand = (int'(r_arbPtr[o]) + k) % NUM_PORTS;
          if (!v_found && w_headValid[v_cand] && !w_drop[v_cand] &&
              (w_target[v_cand] == PTR_W'(o))) begin
            v_found       = 1'b1;
            w_grantIdx[o] = PTR_W'(v_cand);
          end
        end
      end
      w_grantValid[o] = v_found;
    end
  end

  always_comb begin
    w_pop = w_drop;
    for (int o = 0; o < NUM_PORTS; o++) begin
      if (w_grantValid[o]) w_pop[w_grantIdx[o]] = 1'b1;
    end
  end

  always_comb begin
    w_numDrops = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      w_numDrops = w_numDrops + NDROP_W'(w_drop[p]);
    end
    w_dropSum = {1'b0, r_dropCount} + (DROP_CNT_W + 1)'(w_numDrops);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        r_rdPtr[p] <= '0;
        r_wrPtr[p] <= '0;
        r_count[p] <= '0;
      end
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (w_push[p]) r_wrPtr[p] <= r_wrPtr[p] + AW'(1);
        if (w_pop[p])  r_rdPtr[p] <= r_rdPtr[p] + AW'(1);
        case ({w_push[p], w_pop[p]})
          2'b10:   r_count[p] <= r_count[p] + CNT_W'(1);
          2'b01:   r_count[p] <= r_count[p] - CNT_W'(1);
          default: r_count[p] <= r_count[p];
        endcase
      end
    end
  end

  // Storage needs no reset: the counters alone decide what is visible.
  always_ff @(posedge clk) begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (w_push[p]) r_mem[p][r_wrPtr[p]] <= io_bus.in_data[p*WIDTH_PACKET +: WIDTH_PACKET];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_outValid  <= '0;
      r_dropCount <= '0;
      for (int o = 0; o < NUM_PORTS; o++) begin
        r_outData[o] <= '0;
        r_arbPtr[o]  <= '0;
      end
    end else begin
      r_dropCount <= (w_dropSum > DROP_MAX) ? DROP_MAX[DROP_CNT_W-1:0]
                                            : w_dropSum[DROP_CNT_W-1:0];
      for (int o = 0; o < NUM_PORTS; o++) begin
        if (w_grantValid[o]) begin
          r_outValid[o] <= 1'b1;
          r_outData[o]  <= w_head[w_grantIdx[o]];
          r_arbPtr[o]   <= (w_grantIdx[o] == PTR_W'(NUM_PORTS - 1)) ? '0
                                                                    : w_grantIdx[o] + PTR_W'(1);
        end else if (io_bus.out_ready[o]) begin
          r_outValid[o] <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_tree_router_nary.sv
// Directed bench for tree_router_nary. Expected packets are queued per output
// when driven and checked by a negedge monitor as they leave the router.
module tb_tree_router_nary;
  localparam int W      = 14;
  localparam int NCHILD = 2;
  localparam int NP     = NCHILD + 1;
  localparam logic [2:0] RID   = 3'b000;
  localparam logic [2:0] RMASK = 3'b110;

  logic clk;
  logic rst_n;
  int   testCount;
  int   failCount;
  int   expDrop;
  int   popCount [NP];
  logic [W-1:0] q0 [$];
  logic [W-1:0] q1 [$];
  logic [W-1:0] q2 [$];

  tree_router_nary_if #(.WIDTH_PACKET(W), .NUM_CHILD(NCHILD), .DROP_CNT_W(8)) bus ();

  tree_router_nary #(
    .WIDTH_PACKET(W), .NUM_CHILD(NCHILD), .FIFO_DEPTH(4), .ADDR_W(3), .DEST_LSB(0),
    .ROUTER_ID(RID), .ROUTER_MASK(RMASK), .DROP_CNT_W(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .io_bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testCount++;
    assert (got === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int modelTarget(input int src, input logic [W-1:0] d);
    logic [2:0] dest;
    dest = d[2:0];
    if (((dest ^ RID) & RMASK) == 3'b000) return int'(dest[0]) + 1;
    if (src != 0) return 0;
    return -1;
  endfunction

  function automatic int qSize(input int o);
    case (o)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic pushExp(input int o, input logic [W-1:0] d);
    case (o)
      0:       q0.push_back(d);
      1:       q1.push_back(d);
      default: q2.push_back(d);
    endcase
  endtask

  function automatic logic [W-1:0] popExp(input int o);
    case (o)
      0:       return q0.pop_front();
      1:       return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  // Every handshake seen here completes at the following rising edge.
  always @(negedge clk) begin
    for (int o = 0; o < NP; o++) begin
      if (bus.out_valid[o] === 1'b1 && bus.out_ready[o] === 1'b1) begin
        popCount[o]++;
        if (qSize(o) == 0)
          checkOutput($sformatf("stray_out%0d", o), 32'(bus.out_valid[o]), 32'd0);
        else
          checkOutput($sformatf("data_out%0d", o), 32'(bus.out_data[o*W +: W]), 32'(popExp(o)));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int p, input logic [W-1:0] d);
    int t;
    bus.in_valid[p]      = 1'b1;
    bus.in_data[p*W +: W] = d;
    t = modelTarget(p, d);
    if (t < 0) begin
      if (expDrop < 255) expDrop++;
    end else begin
      pushExp(t, d);
    end
  endtask

  task automatic clearInputs();
    bus.in_valid = '0;
    bus.in_data  = '0;
  endtask

  task automatic sendOne(input int p, input logic [W-1:0] d);
    applyStimulus(p, d);
    tick();
    clearInputs();
  endtask

  task automatic waitDrain(input string tag);
    for (int c = 0; c < 50 && (q0.size() + q1.size() + q2.size()) != 0; c++) tick();
    checkOutput(tag, 32'(q0.size() + q1.size() + q2.size()), 32'd0);
  endtask

  task automatic latencyCase(input string tag, input int src, input logic [W-1:0] d, input int dst);
    sendOne(src, d);
    checkOutput({tag, "_quiet"}, 32'(bus.out_valid), 32'd0);
    tick();
    checkOutput({tag, "_valid"}, 32'(bus.out_valid), 32'(1 << dst));
    checkOutput({tag, "_data"}, 32'(bus.out_data[dst*W +: W]), 32'(d));
    waitDrain({tag, "_drain"});
  endtask

  initial begin
    int base;
    testCount = 0;
    failCount = 0;
    expDrop   = 0;
    for (int o = 0; o < NP; o++) popCount[o] = 0;
    rst_n         = 1'b0;
    bus.out_ready = '1;
    clearInputs();

    #1;
    checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd0);
    tick();
    tick();
    checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("rst_out_data", 32'(bus.out_data), 32'd0);
    checkOutput("rst_drop", 32'(bus.drop_count), 32'd0);
    rst_n = 1'b1;
    #1;
    checkOutput("post_rst_in_ready", 32'(bus.in_ready), 32'h7);

    latencyCase("child2", 0, 14'b00001001000001, 2);
    latencyCase("child1", 0, 14'b00000001000000, 1);
    latencyCase("upward", 2, 14'b00010010000010, 0);

    sendOne(0, 14'b00000000100010);
    tick();
    checkOutput("drop_one", 32'(bus.drop_count), 32'(expDrop));
    checkOutput("drop_no_out", 32'(bus.out_valid), 32'd0);
    for (int i = 0; i < 299; i++) begin
      applyStimulus(0, 14'(i << 3) | 14'b010);
      tick();
    end
    clearInputs();
    tick();
    tick();
    checkOutput("drop_sat", 32'(bus.drop_count), 32'(expDrop));

    // Park packets in FIFOs and output registers, then reset over them.
    bus.out_ready = 3'b100;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 14'h0200 + 14'(i << 3));
      applyStimulus(1, 14'h0300 + 14'(i << 3) + 14'b010);
      tick();
    end
    clearInputs();
    tick();
    checkOutput("mid_out_valid", 32'(bus.out_valid), 32'h3);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_in_ready", 32'(bus.in_ready), 32'd0);
    tick();
    checkOutput("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("mid_rst_drop", 32'(bus.drop_count), 32'd0);
    q0.delete();
    q1.delete();
    q2.delete();
    expDrop = 0;
    rst_n = 1'b1;
    bus.out_ready = '1;
    #1;
    checkOutput("mid_post_in_ready", 32'(bus.in_ready), 32'h7);
    for (int i = 0; i < 8; i++) tick();
    checkOutput("mid_no_stale", 32'(bus.out_valid), 32'd0);

    // Contention on port 1 with the pointer at 0, then at 0 again, then at 1.
    for (int burst = 0; burst < 3; burst++) begin
      if (burst == 2) begin
        sendOne(0, 14'h3F00);
        waitDrain("ptr_setup_drain");
      end
      for (int k = 0; k < NP; k++) begin
        int s;
        s = (burst == 2) ? (k + 1) % NP : k;
        applyStimulus(s, 14'h0100 * 14'(s + 1) + 14'(burst << 4));
      end
      tick();
      clearInputs();
      for (int k = 0; k < NP; k++) begin
        int s;
        s = (burst == 2) ? (k + 1) % NP : k;
        tick();
        checkOutput($sformatf("cont%0d_slot%0d", burst, k),
                    32'(bus.out_data[W +: W]), 32'(14'h0100 * 14'(s + 1) + 14'(burst << 4)));
      end
      waitDrain($sformatf("cont%0d_drain", burst));
    end

    // Backpressure: 4 FIFO entries plus the output register absorb 5 packets.
    bus.out_ready = 3'b101;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(0, 14'h1000 + 14'(i << 4));
      checkOutput($sformatf("bp_ready%0d", i), 32'(bus.in_ready[0]), (i < 5) ? 32'd1 : 32'd0);
      if (i < 5) tick();
    end
    tick();
    checkOutput("bp_still_full", 32'(bus.in_ready[0]), 32'd0);
    base = popCount[1];
    bus.out_ready = 3'b111;
    tick();
    checkOutput("bp_sixth_ready", 32'(bus.in_ready[0]), 32'd1);
    tick();
    clearInputs();
    tick();
    tick();
    tick();
    checkOutput("bp_rate", 32'(popCount[1] - base), 32'd5);
    waitDrain("bp_drain");

    checkOutput("final_drop", 32'(bus.drop_count), 32'(expDrop));
    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end
endmodule

// File: doc/tree_router_nary.md
Name: tree_router_nary

Overview:
- Clocked, parametrised successor to the 3-port tree NoC router.
- One parent port plus NUM_CHILD child ports, all using valid/ready handshakes.
- Each input has a FIFO; each output has round-robin arbitration feeding a one-entry output register.
- Address-match routing uses ROUTER_ID/ROUTER_MASK. Misrouted packets are dropped and counted; the router sits at any internal node of the tree.

Parameters:
- WIDTH_PACKET, 14, packet width in bits.
- NUM_CHILD, 2, number of child ports (2..4); NUM_PORTS = NUM_CHILD+1.
- FIFO_DEPTH, 4, entries per input FIFO (power of 2, >=2).
- ADDR_W, 3, destination field width.
- DEST_LSB, 0, LSB position of the dest field in the packet.
- ROUTER_ID, 3'b000, address of this subtree.
- ROUTER_MASK, 3'b110, bits compared against ROUTER_ID. The low CSEL_W=clog2(NUM_CHILD) bits must be 0.
- DROP_CNT_W, 8, drop counter width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  NUM_PORTS  per-input valid; port 0 = parent, port k = child k.
- in_ready  out  NUM_PORTS  per-input ready (FIFO not full).
- in_data  in  NUM_PORTS*WIDTH_PACKET  flattened packets; port p occupies [p*W +: W].
- out_valid  out  NUM_PORTS  per-output valid.
- out_ready  in  NUM_PORTS  per-output ready from the downstream node.
- out_data  out  NUM_PORTS*WIDTH_PACKET  flattened, same packing as in_data.
- drop_count  out  DROP_CNT_W  saturating count of dropped packets.

Behaviour:
- Reset (rst_n low at an edge):
  - All FIFOs are emptied and out_valid = 0.
  - out_data = 0, drop_count = 0, and every arbiter pointer is set to port 0.
  - in_ready = 0 in any cycle where rst_n is low.
  - Reset mid-operation discards all buffered packets without counting them.
- Input:
  - A transfer occurs when in_valid[p] & in_ready[p] at an edge; the packet is written to FIFO p.
  - in_ready[p] = !full[p] and is a registered-state function with no same-cycle bypass.
  - The FIFO head is readable combinationally.
- Routing of the head packet, with dest = data[DEST_LSB +: ADDR_W]:
  - match = ((dest ^ ROUTER_ID) & ROUTER_MASK) == 0.
  - If match, idx = dest[CSEL_W-1:0]. Target is child port idx+1 if idx < NUM_CHILD; otherwise the packet is dropped.
  - If not match and the source is a child, target is port 0 (parent).
  - If not match and the source is the parent, the packet is dropped (misroute).
  - A child may target itself (U-turn allowed).
- Drop:
  - The head is popped in the cycle it appears, with no output.
  - drop_count increases by the number of inputs dropping that cycle and saturates at 2^DROP_CNT_W-1.
- Arbitration, per output o:
  - Requesters are the FIFO heads whose target is o.
  - Output register o may load when !out_valid[o] or out_ready[o] in the same cycle.
  - The grant goes to the first requester at or after ptr[o], wrapping modulo NUM_PORTS.
  - On a grant: the head is popped, the register is loaded, and ptr[o] = granted+1 (mod NUM_PORTS).
  - The pointer is unchanged when there is no grant.
  - An input head has exactly one target, so there are no input-side conflicts.
- Output:
  - out_valid/out_data hold stable until out_ready.
  - A simultaneous drain and load at the same edge yields back-to-back packets at 1 packet/cycle per output.
- Latency:
  - A packet accepted at edge E into an empty FIFO has out_valid asserted after edge E+1.
  - Minimum latency is 2 edges; out_data is bit-identical to in_data.
- Ordering: packets from the same input to the same output leave in arrival order.
- Full FIFO: a simultaneous pop does not raise in_ready until the next cycle.
- Buffering: per input-output path, capacity is FIFO_DEPTH + 1 (output register).

Test Plan:
- Basic routing, child 2: parent sends 14'b00001001000001 (dest 001) -> port 2 out_valid 2 edges later, identical data; no other outputs.
- Basic routing, child 1: parent sends 14'b00000001000000 (dest 000) -> port 1 out_valid 2 edges later, identical data; no other outputs.
- Upward: child2 sends 14'b00010010000010 (dest 010) -> appears on port 0 (parent).
- Misroute drop: parent sends dest 010 -> no out_valid anywhere; drop_count = 1. Repeat 300 times -> drop_count = 255.
- Contention: ports 0,1,2 all send dest 000 in the same cycle -> port 1 emits sources in order 0,1,2 on consecutive cycles. The same burst again -> order 0,1,2 (ptr wrapped to 0); with ptr at 1 -> order 1,2,0.
- Backpressure: out_ready[1] = 0 while the parent sends 6 packets dest 000.
  - 5 are accepted (4 FIFO + 1 output register); in_ready[0] = 0 afterwards.
  - Raising out_ready yields 5 packets in order, one per cycle, and the 6th is then accepted.
- Reset mid-operation: FIFOs partly full and out_valid high -> rst_n low for 1 edge.
  - out_valid = 0, drop_count = 0, in_ready = 0 during reset, in_ready = 1 after.
  - No stale packet ever appears on any output.
